// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding and sizing helper.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STAB   = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4,
        ST_BYPASS = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer; both stages clear to 0 on asynchronous active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer with timeout/retry, stability window, lock-loss monitor and heartbeat LED.
// Optional PLL_SEQ_FALLBACK_BYPASS_EN: retry exhaustion enters BYPASS instead of FAIL.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int LED_DIV_W      = 24
) (
    input  logic               clk,
    input  logic               RESETB,
    input  logic               pll_lock,
    output logic               pll_resetb,
    output logic               pll_bypass,
    output logic               sys_rst_n,
    output logic               ready,
    output logic [7:0]         retry_cnt,
    output logic [7:0]         loss_cnt,
    output logic [STATE_W-1:0] state_o,
    output logic               led
);

    localparam int TIMER_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int TIMER_W   = $clog2(TIMER_MAX) + 1;

    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WAIT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STAB_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]         RETRY_LIM = 8'(MAX_RETRIES);

`ifdef PLL_SEQ_FALLBACK_BYPASS_EN
    localparam state_t EXHAUST_STATE = ST_BYPASS;
`else
    localparam state_t EXHAUST_STATE = ST_FAIL;
`endif

    logic                 lock_s;
    state_t               state_reg, state_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [7:0]           retry_reg, retry_next;
    logic [7:0]           loss_reg, loss_next;
    logic [LED_DIV_W-1:0] divider_reg, divider_next;
    logic                 pll_resetb_reg, pll_resetb_next;
    logic                 sys_rst_n_reg, sys_rst_n_next;
    logic                 ready_reg, ready_next;
    logic                 led_reg, led_next;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (RESETB),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        case (state_reg)
            ST_HOLD: begin
                if (timer_reg == HOLD_LAST) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Lock arriving on the timeout cycle wins over the retry.
                if (lock_s) begin
                    state_next = ST_STAB;
                end else if (timer_reg == WAIT_LAST) begin
                    retry_next = retry_reg + 8'd1;
                    state_next = (retry_next == RETRY_LIM) ? EXHAUST_STATE : ST_HOLD;
                end
            end
            ST_STAB: begin
                if (!lock_s) begin
                    state_next = ST_WAIT;
                end else if (timer_reg == STAB_LAST) begin
                    state_next = ST_RUN;
                    retry_next = 8'd0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_next = ST_HOLD;
                    if (loss_reg != 8'hFF) loss_next = loss_reg + 8'd1;
                end
            end
            ST_FAIL: state_next = ST_FAIL;
`ifdef PLL_SEQ_FALLBACK_BYPASS_EN
            ST_BYPASS: state_next = ST_BYPASS;
`endif
            default: state_next = ST_HOLD;
        endcase

        // Timer restarts on every state change and parks at all-ones in long-lived states.
        if (state_next != state_reg)
            timer_next = '0;
        else if (timer_reg == '1)
            timer_next = timer_reg;
        else
            timer_next = timer_reg + TIMER_W'(1);
    end

    always_comb begin
        divider_next    = divider_reg + LED_DIV_W'(1);
        pll_resetb_next = !((state_next == ST_HOLD) || (state_next == ST_FAIL));
        ready_next      = (state_next == ST_RUN);
        sys_rst_n_next  = (state_next == ST_RUN);
        led_next        = 1'b0;
        case (state_next)
            ST_RUN:  led_next = divider_next[LED_DIV_W-1];
            ST_FAIL: led_next = divider_next[LED_DIV_W-4];
`ifdef PLL_SEQ_FALLBACK_BYPASS_EN
            ST_BYPASS: begin
                led_next       = divider_next[LED_DIV_W-2];
                sys_rst_n_next = 1'b1;
            end
`endif
            default: led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge RESETB) begin
        if (!RESETB) begin
            state_reg      <= ST_HOLD;
            timer_reg      <= '0;
            retry_reg      <= 8'd0;
            loss_reg       <= 8'd0;
            divider_reg    <= '0;
            pll_resetb_reg <= 1'b0;
            sys_rst_n_reg  <= 1'b0;
            ready_reg      <= 1'b0;
            led_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            retry_reg      <= retry_next;
            loss_reg       <= loss_next;
            divider_reg    <= divider_next;
            pll_resetb_reg <= pll_resetb_next;
            sys_rst_n_reg  <= sys_rst_n_next;
            ready_reg      <= ready_next;
            led_reg        <= led_next;
        end
    end

`ifdef PLL_SEQ_FALLBACK_BYPASS_EN
    logic pll_bypass_reg;

    always_ff @(posedge clk or negedge RESETB) begin
        if (!RESETB) pll_bypass_reg <= 1'b0;
        else         pll_bypass_reg <= (state_next == ST_BYPASS);
    end

    assign pll_bypass = pll_bypass_reg;
`else
    assign pll_bypass = 1'b0;
`endif

    assign pll_resetb = pll_resetb_reg;
    assign sys_rst_n  = sys_rst_n_reg;
    assign ready      = ready_reg;
    assign retry_cnt  = retry_reg;
    assign loss_cnt   = loss_reg;
    assign state_o    = state_reg;
    assign led        = led_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized self-checking bench for pll_lock_sequencer against a phase-level reference model.
module tb_pll_lock_sequencer;

    localparam int RST_C  = 4;
    localparam int TO_C   = 32;
    localparam int STAB_C = 8;
    localparam int MAXR   = 2;
    localparam int LED_W  = 6;
    localparam int MAXE   = 6200;
    localparam int MAXA   = 6300;

    localparam int P_HOLD = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4, P_BYPASS = 5;
`ifdef PLL_SEQ_FALLBACK_BYPASS_EN
    localparam int P_EXH = P_BYPASS;
`else
    localparam int P_EXH = P_FAIL;
`endif

    logic       clk = 1'b0;
    logic       RESETB = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_resetb, pll_bypass, sys_rst_n, ready, led;
    logic [7:0] retry_cnt, loss_cnt;
    logic [2:0] state_o;

    int passed = 0;
    int total  = 0;

    bit          lw [0:MAXA-1];
    logic [23:0] obs [0:MAXA-1];
    int          exp_ph [0:MAXA-1];
    int          exp_retry [0:MAXA-1];
    int          exp_loss [0:MAXA-1];
    int          n_model;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES (RST_C),
        .LOCK_TIMEOUT   (TO_C),
        .STABLE_CYCLES  (STAB_C),
        .MAX_RETRIES    (MAXR),
        .LED_DIV_W      (LED_W)
    ) dut (
        .clk        (clk),
        .RESETB     (RESETB),
        .pll_lock   (pll_lock),
        .pll_resetb (pll_resetb),
        .pll_bypass (pll_bypass),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt),
        .state_o    (state_o),
        .led        (led)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Layout: [23:21] state, [20] pll_resetb, [19] pll_bypass, [18] sys_rst_n, [17] ready,
    // [16:9] retry_cnt, [8:1] loss_cnt, [0] led.
    function automatic logic [23:0] dut_vec();
        return {state_o, pll_resetb, pll_bypass, sys_rst_n, ready, retry_cnt, loss_cnt, led};
    endfunction

    // Synchronized lock as seen by the sequencer at edge e (two-edge lag, zero out of reset).
    function automatic bit ls(input int e);
        return (e >= 3) ? lw[e-2] : 1'b0;
    endfunction

    function automatic int first_lock(input int start, input int cnt);
        for (int k = 1; k <= cnt; k++) if (ls(start + k)) return k;
        return 0;
    endfunction

    function automatic int first_drop(input int start, input int cnt);
        for (int k = 1; k <= cnt; k++) if (!ls(start + k)) return k;
        return 0;
    endfunction

    function automatic void mark(input int e, input int ph, input int r, input int l);
        if (e <= n_model) begin
            exp_ph[e] = ph;
            exp_retry[e] = r;
            exp_loss[e] = l;
        end
    endfunction

    // Walks the sequence phase by phase: each phase's length is found by scanning the lock waveform.
    function automatic void build_model(input int n);
        int e, ph, nph, dur, d0, retry, loss, nretry, nloss;
        n_model = n;
        e = 0; ph = P_HOLD; retry = 0; loss = 0;
        mark(0, ph, retry, loss);
        while (e < n) begin
            nretry = retry; nloss = loss;
            case (ph)
                P_HOLD: begin dur = RST_C; nph = P_WAIT; end
                P_WAIT: begin
                    d0 = first_lock(e, TO_C);
                    if (d0 != 0) begin dur = d0; nph = P_STAB; end
                    else begin
                        dur = TO_C; nretry = retry + 1;
                        nph = (nretry == MAXR) ? P_EXH : P_HOLD;
                    end
                end
                P_STAB: begin
                    d0 = first_drop(e, STAB_C);
                    if (d0 != 0) begin dur = d0; nph = P_WAIT; end
                    else begin dur = STAB_C; nph = P_RUN; nretry = 0; end
                end
                P_RUN: begin
                    d0 = first_drop(e, n - e);
                    if (d0 != 0) begin
                        dur = d0; nph = P_HOLD;
                        nloss = (loss < 255) ? loss + 1 : 255;
                    end else begin dur = n - e; nph = P_RUN; end
                end
                default: begin dur = n - e; nph = ph; end
            endcase
            for (int k = 1; k < dur; k++) mark(e + k, ph, retry, loss);
            mark(e + dur, nph, nretry, nloss);
            e += dur; ph = nph; retry = nretry; loss = nloss;
        end
    endfunction

    function automatic logic [23:0] exp_vec(input int e);
        int ph;
        logic rb, bp, sr, rd, ld;
        ph = exp_ph[e];
        rb = !(ph == P_HOLD || ph == P_FAIL);
        bp = (ph == P_BYPASS);
        sr = (ph == P_RUN || ph == P_BYPASS);
        rd = (ph == P_RUN);
        ld = 1'b0;
        if (ph == P_RUN)    ld = ((e >> (LED_W-1)) & 1) != 0;
        if (ph == P_FAIL)   ld = ((e >> (LED_W-4)) & 1) != 0;
        if (ph == P_BYPASS) ld = ((e >> (LED_W-2)) & 1) != 0;
        return {3'(ph), rb, bp, sr, rd, 8'(exp_retry[e]), 8'(exp_loss[e]), ld};
    endfunction

    task automatic clear_wave();
        for (int i = 0; i < MAXA; i++) lw[i] = 1'b0;
    endtask

    // Resets the DUT, releases RESETB at a falling edge and records outputs after each edge 0..n.
    task automatic run_wave(input int n);
        RESETB = 1'b0;
        pll_lock = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs[0] = dut_vec();
        pll_lock = lw[1];
        RESETB = 1'b1;
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            obs[e] = dut_vec();
            pll_lock = lw[e+1];
        end
    endtask

    task automatic test_reset();
        RESETB = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pll_lock = i[0];
            @(negedge clk);
            total++;
            if (dut_vec() !== 24'h0) $display("FAIL reset cycle=%0d got=%h expected=%h", i, dut_vec(), 24'h0);
            else passed++;
        end
    endtask

    task automatic test_acquire();
        int t, r, n;
        for (int it = 0; it < 3; it++) begin
            t = $urandom_range(1, 25);
            n = 60;
            clear_wave();
            for (int e = t; e < MAXA; e++) lw[e] = 1'b1;
            build_model(n);
            run_wave(n);
            for (int e = 0; e <= n; e++) begin
                total++;
                if (obs[e] !== exp_vec(e)) $display("FAIL acquire t=%0d edge=%0d got=%h expected=%h", t, e, obs[e], exp_vec(e));
                else passed++;
            end
            r = ((t + 2 > 5) ? t + 2 : 5) + STAB_C;
            total++;
            if (obs[r][17] !== 1'b1 || obs[r-1][17] !== 1'b0 || obs[r][16:9] !== 8'd0)
                $display("FAIL acquire_ready_edge t=%0d edge=%0d got=%b%b expected=01", t, r, obs[r-1][17], obs[r][17]);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        int t, s, g, n;
        for (int it = 0; it < 3; it++) begin
            t = $urandom_range(1, 8);
            s = (t + 2 > 5) ? t + 2 : 5;
            g = s + $urandom_range(0, 5);
            n = 80;
            clear_wave();
            for (int e = t; e < MAXA; e++) lw[e] = (e < g || e > g + 2);
            build_model(n);
            run_wave(n);
            for (int e = 0; e <= n; e++) begin
                total++;
                if (obs[e] !== exp_vec(e)) $display("FAIL glitch g=%0d edge=%0d got=%h expected=%h", g, e, obs[e], exp_vec(e));
                else passed++;
            end
            total++;
            if (obs[g+2][23:21] !== 3'd1) $display("FAIL glitch_to_wait edge=%0d got=%0d expected=1", g + 2, obs[g+2][23:21]);
            else passed++;
            total++;
            if (obs[g+13][17] !== 1'b1 || obs[g+12][17] !== 1'b0)
                $display("FAIL glitch_ready_edge edge=%0d got=%b%b expected=01", g + 13, obs[g+12][17], obs[g+13][17]);
            else passed++;
        end
    endtask

    task automatic test_no_lock();
        int n;
        logic [23:0] fin;
        n = 90;
        clear_wave();
        build_model(n);
        run_wave(n);
        for (int e = 0; e <= n; e++) begin
            total++;
            if (obs[e] !== exp_vec(e)) $display("FAIL no_lock edge=%0d got=%h expected=%h", e, obs[e], exp_vec(e));
            else passed++;
        end
        fin = obs[n];
        total++;
        if (fin[23:21] !== 3'(P_EXH) || fin[16:9] !== 8'd2 || fin[18] !== (P_EXH == P_BYPASS) || fin[19] !== (P_EXH == P_BYPASS))
            $display("FAIL no_lock_final got=%h expected state=%0d retry=2", fin, P_EXH);
        else passed++;
    endtask

    task automatic test_lock_loss();
        int t, d, n;
        t = $urandom_range(1, 10);
        d = t + 30;
        n = d + 40;
        clear_wave();
        for (int e = t; e < MAXA; e++) lw[e] = (e != d);
        build_model(n);
        run_wave(n);
        for (int e = 0; e <= n; e++) begin
            total++;
            if (obs[e] !== exp_vec(e)) $display("FAIL lock_loss edge=%0d got=%h expected=%h", e, obs[e], exp_vec(e));
            else passed++;
        end
        total++;
        if (obs[d+1][18] !== 1'b1 || obs[d+2][18] !== 1'b0 || obs[d+2][23:21] !== 3'd0 || obs[n][8:1] !== 8'd1 || obs[n][17] !== 1'b1)
            $display("FAIL lock_loss_events got=%h,%h,%h expected sys_rst_n fall at edge %0d, loss_cnt=1", obs[d+1], obs[d+2], obs[n], d + 2);
        else passed++;
    endtask

    task automatic test_async_reset();
        int n;
        n = 60;
        clear_wave();
        for (int e = 1; e < MAXA; e++) lw[e] = 1'b1;
        build_model(n);
        RESETB = 1'b0;
        pll_lock = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        pll_lock = lw[1];
        RESETB = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            total++;
            if (dut_vec() !== exp_vec(e)) $display("FAIL async_pre edge=%0d got=%h expected=%h", e, dut_vec(), exp_vec(e));
            else passed++;
            pll_lock = lw[e+1];
        end
        #2;
        RESETB = 1'b0;
        #1;
        total++;
        if (dut_vec() !== 24'h0) $display("FAIL async_reset got=%h expected=%h", dut_vec(), 24'h0);
        else passed++;
        #1;
        RESETB = 1'b1;
        run_wave(n);
        for (int e = 0; e <= n; e++) begin
            total++;
            if (obs[e] !== exp_vec(e)) $display("FAIL async_restart edge=%0d got=%h expected=%h", e, obs[e], exp_vec(e));
            else passed++;
        end
    endtask

    task automatic test_loss_saturate();
        int n, bad;
        n = 6060;
        clear_wave();
        for (int e = 1; e < MAXA; e++) lw[e] = 1'b1;
        for (int i = 0; i < 300; i++) lw[40 + 20*i] = 1'b0;
        build_model(n);
        run_wave(n);
        bad = 0;
        for (int e = 0; e <= n; e++) begin
            total++;
            if (obs[e] !== exp_vec(e)) begin
                if (bad < 20) $display("FAIL loss_saturate edge=%0d got=%h expected=%h", e, obs[e], exp_vec(e));
                bad++;
            end else passed++;
        end
        total++;
        if (obs[n][8:1] !== 8'd255 || obs[n][23:21] !== 3'd3)
            $display("FAIL loss_saturate_final got loss=%0d state=%0d expected loss=255 state=3", obs[n][8:1], obs[n][23:21]);
        else passed++;
    endtask

    task automatic test_random();
        int n, pos, len;
        bit lvl;
        for (int it = 0; it < 4; it++) begin
            n = 400;
            clear_wave();
            pos = 1;
            lvl = 1'($urandom_range(0, 1));
            while (pos < MAXA) begin
                len = $urandom_range(1, 40);
                for (int k = 0; k < len && pos < MAXA; k++) begin
                    lw[pos] = lvl;
                    pos++;
                end
                lvl = !lvl;
            end
            build_model(n);
            run_wave(n);
            for (int e = 0; e <= n; e++) begin
                total++;
                if (obs[e] !== exp_vec(e)) $display("FAIL random it=%0d edge=%0d got=%h expected=%h", it, e, obs[e], exp_vec(e));
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_glitch();
        test_no_lock();
        test_lock_loss();
        test_async_reset();
        test_loss_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
